// File: rtl/memory_controller.sv
// Shared backing memory for two caches: round-robin arbitration, fixed-latency
// read / byte write on 16-bit words, and cross-port invalidation on writes.
module memory_controller #(
   parameter int MEM_WORD_BITS = 8,
   parameter int MEM_LATENCY   = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [24:0] memory_request_0,
   input  logic [24:0] memory_request_1,
   input  logic        memory_request_ready_0,
   input  logic        memory_request_ready_1,
   output logic [15:0] memory_response_0,
   output logic [15:0] memory_response_1,
   output logic        memory_response_ready_0,
   output logic        memory_response_ready_1,
   output logic [15:0] invalidate_address_0,
   output logic [15:0] invalidate_address_1
);

   localparam int DEPTH = 1 << MEM_WORD_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        armed_q, armed_d;
   logic              last_grant_q, last_grant_d;
   logic              port_q, port_d;
   logic [24:0]       req_q, req_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0][15:0]  resp_q, resp_d;
   logic [1:0][15:0]  inv_q, inv_d;
   logic [1:0]        rdy_q, rdy_d;

   logic [15:0]       mem [DEPTH];

   logic [1:0]               req_valid;
   logic [1:0]               eligible;
   logic                     grant_en;
   logic                     grant_port;
   logic                     req_rw;
   logic [7:0]               req_data;
   logic [15:0]              req_addr;
   logic [MEM_WORD_BITS-1:0] index;
   logic [15:0]              rd_word;
   logic [15:0]              merged;
   logic                     op_fire;

   assign req_valid = {memory_request_ready_1, memory_request_ready_0};
   assign eligible  = req_valid & armed_q;
   assign grant_en  = |eligible;
   // On a tie the port that did not win last time goes first.
   assign grant_port = (&eligible) ? ~last_grant_q : eligible[1];

   assign req_rw   = req_q[24];
   assign req_data = req_q[23:16];
   assign req_addr = req_q[15:0];
   assign index    = req_addr[MEM_WORD_BITS:1];
   assign rd_word  = mem[index];
   assign merged   = req_addr[0] ? {req_data, rd_word[7:0]} : {rd_word[15:8], req_data};
   assign op_fire  = (state_q == ACCESS) && (cnt_q == 4'd0);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         armed_q      <= 2'b11;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         req_q        <= '0;
         cnt_q        <= '0;
         resp_q       <= '0;
         inv_q        <= '0;
         rdy_q        <= '0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         req_q        <= req_d;
         cnt_q        <= cnt_d;
         resp_q       <= resp_d;
         inv_q        <= inv_d;
         rdy_q        <= rdy_d;
      end
   end

   // NOTE: the array has no reset; contents survive reset, and an abandoned
   // access never writes because reset forces the FSM out of ACCESS.
   always_ff @(posedge clock) begin
      if (op_fire && req_rw) begin
         mem[index] <= merged;
      end
   end

   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_en) state_d = ACCESS;
         ACCESS:  if (cnt_q == 4'd0) state_d = RESPOND;
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      // Re-arm whenever the cache lets go of its request.
      armed_d      = armed_q | ~req_valid;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      req_d        = req_q;
      cnt_d        = cnt_q;
      resp_d       = resp_q;
      inv_d        = inv_q;
      rdy_d        = '0;
      unique case (state_q)
         IDLE: begin
            if (grant_en) begin
               armed_d[grant_port] = 1'b0;
               last_grant_d        = grant_port;
               port_d              = grant_port;
               req_d               = grant_port ? memory_request_1 : memory_request_0;
               cnt_d               = 4'(MEM_LATENCY - 1);
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               resp_d[port_q] = req_rw ? merged : rd_word;
               rdy_d[port_q]  = 1'b1;
               if (req_rw) inv_d[~port_q] = req_addr;
            end
         end
         default: ;
      endcase
   end

   assign memory_response_0       = resp_q[0];
   assign memory_response_1       = resp_q[1];
   assign memory_response_ready_0 = rdy_q[0];
   assign memory_response_ready_1 = rdy_q[1];
   assign invalidate_address_0    = inv_q[0];
   assign invalidate_address_1    = inv_q[1];

endmodule
